mux8_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 data multiplexer (WIDTH-bit, 3-bit select) among eight requesters.
- Registers a one-hot grant and drives the mux select so the granted source's data reaches the shared bus.
- A hold counter bounds how long one requester may keep the bus, so no requester starves another.
- Sits between requesting units and the shared mux in the CPU datapath.

---
 rtl/mux8_arbiter_pkg.sv | 18 +
 rtl/mux8_arbiter_if.sv | 14 +
 rtl/mux8_arbiter_rr_pick8.sv | 41 ++++
 rtl/mux8_arbiter.sv | 115 +++++++++++
 tb/tb_mux8_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mux8_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the mux8 round-robin arbiter.
package mux8_arbiter_pkg;

  localparam int NUM_REQ   = 8;
  localparam int SEL_WIDTH = 3;

  // Arbiter control states: nobody on the bus, or one requester owns it.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_WIDTH-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux8_arbiter_if.sv
// Request/grant bundle between the requesting units and the arbiter.
interface mux8_arbiter_if;
  import mux8_arbiter_pkg::*;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   grant;
  logic [SEL_WIDTH-1:0] select;
  logic                 busy;

  // Requesting side: raises requests, observes who owns the mux.
  modport master (output req, input grant, input select, input busy);
  // Arbiter side: samples requests, drives grant and mux select.
  modport slave  (input req, output grant, output select, output busy);
endinterface

// File: rtl/mux8_arbiter_rr_pick8.sv
// Combinational round-robin picker: first eligible request at or after ptr.
module mux8_arbiter_rr_pick8
  import mux8_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   mask_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic                 found_o,
  output logic [SEL_WIDTH-1:0] index_o
);

  logic [NUM_REQ-1:0]   eligible_s;
  logic [NUM_REQ-1:0]   rotated_s;
  logic [SEL_WIDTH-1:0] offset_s;

  assign eligible_s = req_i & ~mask_i;

  // Rotate right by ptr so the search always starts at bit 0.
  always_comb begin
    rotated_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated_s[i] = eligible_s[3'(i) + ptr_i];
    end
  end

  // Lowest set bit of the rotated vector is the distance from ptr.
  always_comb begin
    offset_s = {SEL_WIDTH{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated_s[i]) begin
        offset_s = 3'(i);
      end else begin
        offset_s = offset_s;
      end
    end
  end

  assign found_o = |rotated_s;
  assign index_o = offset_s + ptr_i;

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among eight requesters, with a
// hold limit so a continuously requesting owner cannot starve the others.
module mux8_arbiter
  import mux8_arbiter_pkg::*;
#(
  parameter int MAX_HOLD  = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  mux8_arbiter_if.slave bus
);

  // Counter value reached on the owner's last permitted cycle.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_HOLD - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0] select_q, select_d;
  logic                 busy_q, busy_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   mask_s;
  logic                 found_s;
  logic [SEL_WIDTH-1:0] pick_s;
  logic                 owner_req_s;

  // While owned, the current owner is excluded from re-arbitration.
  assign mask_s      = (state_q == ST_OWNED) ? onehot8(select_q) : {NUM_REQ{1'b0}};
  assign owner_req_s = bus.req[select_q];

  mux8_arbiter_rr_pick8 u_pick (
    .req_i   (bus.req),
    .mask_i  (mask_s),
    .ptr_i   (ptr_q),
    .found_o (found_s),
    .index_o (pick_s)
  );

  // Next-state and output decisions for idle arbitration, hold and handoff.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d  = ST_OWNED;
          grant_d  = onehot8(pick_s);
          select_d = pick_s;
          busy_d   = 1'b1;
          ptr_d    = pick_s + 3'd1;
          cnt_d    = {CNT_WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWNED: begin
        if (owner_req_s && (cnt_q != CNT_LAST)) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (found_s) begin
          // Owner released or timed out and someone else is waiting.
          grant_d  = onehot8(pick_s);
          select_d = pick_s;
          busy_d   = 1'b1;
          ptr_d    = pick_s + 3'd1;
          cnt_d    = {CNT_WIDTH{1'b0}};
        end else if (!owner_req_s) begin
          // Owner released with nobody waiting; select keeps the mux stable.
          state_d = ST_IDLE;
          grant_d = {NUM_REQ{1'b0}};
          busy_d  = 1'b0;
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else begin
          // Timed out but unopposed: the owner starts a fresh hold window.
          cnt_d = {CNT_WIDTH{1'b0}};
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_REQ{1'b0}};
        busy_d  = 1'b0;
        cnt_d   = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= {NUM_REQ{1'b0}};
      select_q <= {SEL_WIDTH{1'b0}};
      busy_q   <= 1'b0;
      ptr_q    <= {SEL_WIDTH{1'b0}};
      cnt_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.select = select_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD=16 and MAX_HOLD=1), each feeding
// a shared 8:1 data mux with source i carrying 8'hA0+i.
module tb_mux8_arbiter;

  logic clock;
  logic reset;

  mux8_arbiter_if bus_a ();
  mux8_arbiter_if bus_b ();

  mux8_arbiter #(.MAX_HOLD(16), .CNT_WIDTH(8)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  mux8_arbiter #(.MAX_HOLD(1), .CNT_WIDTH(8)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  // Shared data mux driven by the arbiter selects.
  logic [7:0] d_s [8];
  logic [7:0] y_a, y_b;
  assign y_a = d_s[bus_a.select];
  assign y_b = d_s[bus_b.select];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;
  string cur_tag = "reset";

  // Reference model: owner index (-1 = nobody), last select, search start,
  // number of consecutive cycles the owner has had the grant.
  int m_owner [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_held  [2];
  int m_max   [2];

  function automatic int pick(input logic [7:0] r, input int p, input int skip);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (p + k) % 8;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic take(input int id, input int w);
    m_owner[id] = w;
    m_sel[id]   = w;
    m_ptr[id]   = (w + 1) % 8;
    m_held[id]  = 1;
  endtask

  task automatic model_edge(input int id, input logic rst_v, input logic [7:0] r);
    exp_t e;
    int   w;
    if (!rst_v) begin
      m_owner[id] = -1; m_sel[id] = 0; m_ptr[id] = 0; m_held[id] = 0;
    end else if (m_owner[id] < 0) begin
      w = pick(r, m_ptr[id], -1);
      if (w >= 0) take(id, w);
    end else if (r[m_owner[id]] && m_held[id] < m_max[id]) begin
      m_held[id]++;
    end else begin
      w = pick(r, m_ptr[id], m_owner[id]);
      if (w >= 0) take(id, w);
      else if (!r[m_owner[id]]) m_owner[id] = -1;
      else m_held[id] = 1;
    end
    e.id    = id;
    e.grant = (m_owner[id] >= 0) ? (8'd1 << m_owner[id]) : 8'd0;
    e.sel   = 3'(m_sel[id]);
    e.busy  = (m_owner[id] >= 0);
    e.tag   = cur_tag;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs and record what both arbiters must show after it.
  task automatic step(input logic rst_v, input logic [7:0] ra, input logic [7:0] rb);
    @(negedge clock);
    reset     = rst_v;
    bus_a.req = ra;
    bus_b.req = rb;
    model_edge(0, rst_v, ra);
    model_edge(1, rst_v, rb);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  // Monitor: after every rising edge, compare each DUT against its queued expectation.
  exp_t       m_e;
  logic [7:0] m_g, m_y;
  logic [2:0] m_s;
  logic       m_b;
  string      m_n;
  always @(posedge clock) begin
    #1;
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      if (m_e.id == 0) begin
        m_g = bus_a.grant; m_s = bus_a.select; m_b = bus_a.busy; m_y = y_a;
      end else begin
        m_g = bus_b.grant; m_s = bus_b.select; m_b = bus_b.busy; m_y = y_b;
      end
      m_n = $sformatf("%s[dut%0d]", m_e.tag, m_e.id);
      chk({m_n, ".grant"},  32'(m_g), 32'(m_e.grant));
      chk({m_n, ".select"}, 32'(m_s), 32'(m_e.sel));
      chk({m_n, ".busy"},   32'(m_b), 32'(m_e.busy));
      chk({m_n, ".y"},      32'(m_y), 32'(8'hA0 + 8'(m_e.sel)));
      chk({m_n, ".onehot0"}, 32'($onehot0(m_g)), 32'(1));
      chk({m_n, ".busy_or"}, 32'(m_b), 32'(|m_g));
      if (m_b) chk({m_n, ".grant_sel"}, 32'(m_g), 32'(8'd1 << m_s));
    end
  end

  logic [7:0] rnd_a, rnd_b;

  initial begin
    for (int i = 0; i < 8; i++) d_s[i] = 8'hA0 + 8'(i);
    m_max[0] = 16;
    m_max[1] = 1;
    reset     = 1'b0;
    bus_a.req = 8'h00;
    bus_b.req = 8'h00;

    cur_tag = "reset";
    repeat (2) step(1'b0, 8'h00, 8'h00);

    cur_tag = "reset_mid_grant";
    repeat (3) step(1'b1, 8'h04, 8'hFF);
    step(1'b0, 8'h04, 8'hFF);

    cur_tag = "rotate_all";
    repeat (18) step(1'b1, 8'h00, 8'hFF);

    cur_tag = "single_req";
    repeat (3) step(1'b1, 8'h04, 8'h00);
    repeat (2) step(1'b1, 8'h00, 8'h00);

    cur_tag = "handoff";
    repeat (2) step(1'b1, 8'h08, 8'h08);
    repeat (2) step(1'b1, 8'h28, 8'h28);
    repeat (2) step(1'b1, 8'h20, 8'h20);
    step(1'b1, 8'h00, 8'h00);

    cur_tag = "timeout";
    step(1'b1, 8'h02, 8'h02);
    repeat (22) step(1'b1, 8'h42, 8'h42);
    step(1'b1, 8'h00, 8'h00);

    cur_tag = "lone_hold";
    repeat (40) step(1'b1, 8'h10, 8'h10);
    step(1'b1, 8'h00, 8'h00);

    cur_tag = "ptr_fair";
    step(1'b0, 8'h00, 8'h00);
    repeat (2) step(1'b1, 8'h01, 8'h01);
    step(1'b1, 8'h00, 8'h00);
    repeat (3) step(1'b1, 8'h81, 8'h81);

    cur_tag = "random";
    rnd_a = 8'h00;
    rnd_b = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3, 0) == 0) rnd_a ^= 8'd1 << $urandom_range(7, 0);
      if ($urandom_range(3, 0) == 0) rnd_b ^= 8'd1 << $urandom_range(7, 0);
      if ($urandom_range(40, 0) == 0) rnd_a = 8'h00;
      if ($urandom_range(40, 0) == 0) rnd_b = 8'(($urandom()));
      step(($urandom_range(60, 0) != 0), rnd_a, rnd_b);
    end

    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) chk("scoreboard_drain", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
